// File: rtl/div_pkg.sv
// Shared constants and types for the iterative divider.
// The optional divide-by-zero fast path is enabled with DIV_ZERO_FAST_EN.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for applying the result signs.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? ('0 - a) : a;

endmodule

// File: rtl/div_calculate.sv
// Radix-2 restoring divider for DIV/DIVU feeding HI (remainder) and LO (quotient).
// Define DIV_ZERO_FAST_EN for the divisor==0 shortcut and the div_zero output.
module div_calculate
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FAST_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = cnt_bits(WIDTH);

  state_t state;
  state_t state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             sign_r;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic             fast_zero;

  assign sa = is_signed & dividend[WIDTH-1];
  assign sb = is_signed & divisor[WIDTH-1];

`ifdef DIV_ZERO_FAST_EN
  logic zero_flag;
  assign fast_zero = (divisor == '0);
`else
  assign fast_zero = 1'b0;
`endif

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .a   (dividend),
    .neg (sa),
    .y   (dvd_abs)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .a   (divisor),
    .neg (sb),
    .y   (dvs_abs)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .a   (quo),
    .neg (sign_q),
    .y   (q_fix)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .a   (rem[WIDTH-1:0]),
    .neg (sign_r),
    .y   (r_fix)
  );

  // Extra top bit makes the trial-subtract sign unambiguous.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {2'b00, dvs};

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = fast_zero ? FIX : CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(WIDTH - 1)) begin
          state_nx = FIX;
        end
      end
      FIX: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FAST_EN
      zero_flag <= 1'b0;
      div_zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvs    <= dvs_abs;
            sign_q <= sa ^ sb;
            sign_r <= sa;
            cnt    <= '0;
            // Shortcut preloads the final magnitudes for FIX.
            if (fast_zero) begin
              rem    <= {1'b0, dvd_abs};
              quo    <= '1;
              sign_q <= 1'b0;
            end else begin
              rem <= '0;
              quo <= dvd_abs;
            end
`ifdef DIV_ZERO_FAST_EN
            zero_flag <= fast_zero;
`endif
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (diff[WIDTH+1]) begin
            rem <= rem_sh[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end else begin
            rem <= diff[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          done      <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
          div_zero  <= zero_flag;
`endif
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_calculate.sv
// Directed bench for div_calculate with a cycle-level reference model.
// Build with DIV_ZERO_FAST_EN defined to exercise the divide-by-zero shortcut.
module tb_div_calculate;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          is_signed = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
`ifdef DIV_ZERO_FAST_EN
  logic          div_zero;
`endif

  div_calculate #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_FAST_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: magnitudes in 33+ bits, truncating division.
  function automatic void ref_div(input logic s, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] q,
                                  output logic [W-1:0] r);
    logic [63:0] ma, mb, qm, rm;
    logic pa, pb;
    pa = s & a[W-1];
    pb = s & b[W-1];
    ma = pa ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
    mb = pb ? (64'h1_0000_0000 - {32'b0, b}) : {32'b0, b};
    if (mb == 0) begin
      qm = 64'hFFFF_FFFF;
      rm = ma;
    end else begin
      qm = ma / mb;
      rm = ma % mb;
    end
    q = (pa ^ pb) ? (32'h0 - qm[31:0]) : qm[31:0];
    r = pa ? (32'h0 - rm[31:0]) : rm[31:0];
`ifdef DIV_ZERO_FAST_EN
    if (b == '0) begin
      q = '1;
      r = a;
    end
`endif
  endfunction

  function automatic int lat_of(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == '0) return 1;
`endif
    return LAT;
  endfunction

  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic         m_dz = 1'b0;
  logic [W-1:0] p_q, p_r;
  logic         p_dz;
  int           m_left = 0;

  // Model: one request in flight, result appears a fixed number of edges later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_dz   = 1'b0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_q    = p_q;
          m_r    = p_r;
          m_dz   = p_dz;
        end
      end else if (start) begin
        ref_div(is_signed, dividend, divisor, p_q, p_r);
`ifdef DIV_ZERO_FAST_EN
        p_dz = (divisor == '0);
`else
        p_dz = 1'b0;
`endif
        m_busy = 1'b1;
        m_left = lat_of(divisor);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
`ifdef DIV_ZERO_FAST_EN
      chk("div_zero", {31'b0, div_zero}, {31'b0, m_dz});
`endif
    end
  end

  // Drive a request now; returns the cycle stamp of the accepting edge.
  task automatic go(input logic s, input logic [W-1:0] a,
                    input logic [W-1:0] b, output int t0);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int t0,
                           input int exp_lat, output int bc);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    bc = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (busy) bc++;
    end
    chk({name, " done seen"}, {31'b0, seen}, 32'd1);
    chk({name, " latency"}, cyc - t0, exp_lat);
  endtask

  task automatic run(input string name, input logic s,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er);
    int t0, bc;
    @(posedge clk);
    #1;
    go(s, a, b, t0);
    wait_done(name, t0, lat_of(b), bc);
    chk({name, " q"}, quotient, eq);
    chk({name, " r"}, remainder, er);
    @(negedge clk);
    chk({name, " pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int t0, bc, nd;
    logic [W-1:0] q0;

    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst q", quotient, 32'd0);
    chk("rst r", remainder, 32'd0);

    @(posedge clk);
    #1;
    go(1'b0, 32'd100, 32'd7, t0);
    wait_done("divu100_7", t0, LAT, bc);
    chk("divu100_7 busy cycles", bc, 32'd33);
    chk("divu100_7 q", quotient, 32'd14);
    chk("divu100_7 r", remainder, 32'd2);
    @(negedge clk);
    chk("divu100_7 pulse", {31'b0, done}, 32'd0);

    run("div-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("div7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run("div_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 32'd0);
    run("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 32'h8000_0000);

    // Start while busy is dropped; start in the done cycle is taken.
    @(posedge clk);
    #1;
    go(1'b0, 32'd1000, 32'd10, t0);
    repeat (9) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 32'd55;
    divisor  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start", t0, LAT, bc);
    chk("busy_start q", quotient, 32'd100);
    chk("busy_start r", remainder, 32'd0);
    go(1'b1, 32'hFFFF_FF9C, 32'd3, t0);
    chk("b2b hold q", quotient, 32'd100);
    wait_done("b2b", t0, LAT, bc);
    chk("b2b q", quotient, 32'hFFFF_FFDF);
    chk("b2b r", remainder, 32'hFFFF_FFFF);

    // Reset mid-run aborts without a done.
    @(posedge clk);
    #1;
    go(1'b0, 32'd1234, 32'd5, t0);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort q", quotient, 32'd0);
    chk("abort r", remainder, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort no done", nd, 32'd0);
    run("after_abort", 1'b0, 32'd81, 32'd9, 32'd9, 32'd0);

`ifdef DIV_ZERO_FAST_EN
    @(posedge clk);
    #1;
    go(1'b0, 32'd5, 32'd0, t0);
    wait_done("divu5_0", t0, 1, bc);
    chk("divu5_0 dz", {31'b0, div_zero}, 32'd1);
    chk("divu5_0 q", quotient, 32'hFFFF_FFFF);
    chk("divu5_0 r", remainder, 32'd5);
    run("div-5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
`else
    run("divu5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    run("div-5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB);
`endif

    run("divu0_3", 1'b0, 32'd0, 32'd3, 32'd0, 32'd0);
    run("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    ref_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, q0, p_r);
    chk("model -100/-7 q", q0, 32'd14);
    run("div-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,
        32'hFFFF_FFFE);
    run("divu_big", 1'b0, 32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_DEAD,
        32'h0000_BEEF);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
